spi_arb2: RTL

//  Two-requester round-robin arbiter/sequencer in front of the shared 16-bit SPI master.

---
 rtl/spi_arb_pkg.sv | 20 ++
 rtl/spi_arb2_rr.sv | 14 +
 rtl/spi_arb2.sv | 133 +++++++++++++
 3 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and sizes for the two-requester SPI arbiter.
package spi_arb_pkg;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned CMD_W   = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    WAIT_LO = 3'd2,
    WAIT_HI = 3'd3,
    RESP    = 3'd4
  } arb_state_t;

  // One-hot pulse vector addressed to requester g.
  function automatic logic [NUM_REQ-1:0] gnt_onehot(input logic g);
    return NUM_REQ'(1) << g;
  endfunction

endpackage

// File: rtl/spi_arb2_rr.sv
// Two-way round-robin pick: on contention, the requester not served last wins.
module rr_arb2
  import spi_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last_gnt,
  output logic               any,
  output logic               winner
);

  assign any    = |req;
  assign winner = (req[1] && req[0]) ? ~last_gnt : req[1];

endmodule

// File: rtl/spi_arb2.sv
// Arbitrates two requesters onto one SPI master: launch, wait for done, ack or
// abort on watchdog, and route the master's slave select to the granted device.
module spi_arb2
  import spi_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [CMD_W-1:0]   cmd0,
  input  logic [CMD_W-1:0]   cmd1,
  output logic [NUM_REQ-1:0] ack,
  output logic [NUM_REQ-1:0] err,
  output logic [CMD_W-1:0]   rd_data,
  output logic               spi_wrt,
  output logic [CMD_W-1:0]   spi_cmd,
  input  logic               spi_done,
  input  logic [CMD_W-1:0]   spi_rd_data,
  input  logic               spi_SS_n,
  output logic [NUM_REQ-1:0] ss_n
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC);

  arb_state_t         state, state_d;
  logic               gnt, gnt_d;
  logic               last_gnt, last_gnt_d;
  logic [TMO_W-1:0]   tmo_cnt, tmo_d, tmo_inc;
  logic [CMD_W-1:0]   spi_cmd_d, rd_data_d;
  logic [NUM_REQ-1:0] ack_d, err_d;
  logic               spi_wrt_d;
  logic               any, winner, tmo_hit;

  rr_arb2 u_rr (
    .req      (req),
    .last_gnt (last_gnt),
    .any      (any),
    .winner   (winner)
  );

  // Watchdog saturates at its terminal count instead of wrapping.
  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
  assign tmo_inc = tmo_hit ? tmo_cnt : tmo_cnt + TMO_W'(1);

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
      tmo_cnt  <= '0;
      spi_cmd  <= '0;
      rd_data  <= '0;
      ack      <= '0;
      err      <= '0;
      spi_wrt  <= 1'b0;
    end else begin
      state    <= state_d;
      gnt      <= gnt_d;
      last_gnt <= last_gnt_d;
      tmo_cnt  <= tmo_d;
      spi_cmd  <= spi_cmd_d;
      rd_data  <= rd_data_d;
      ack      <= ack_d;
      err      <= err_d;
      spi_wrt  <= spi_wrt_d;
    end
  end

  // Next state; pulses are raised on the transition into the state they mark.
  always_comb begin
    state_d    = state;
    gnt_d      = gnt;
    last_gnt_d = last_gnt;
    tmo_d      = tmo_cnt;
    spi_cmd_d  = spi_cmd;
    rd_data_d  = rd_data;
    ack_d      = '0;
    err_d      = '0;
    spi_wrt_d  = 1'b0;
    unique case (state)
      IDLE: begin
        if (any) begin
          gnt_d     = winner;
          spi_cmd_d = winner ? cmd1 : cmd0;
          spi_wrt_d = 1'b1;
          state_d   = LAUNCH;
        end
      end
      LAUNCH: begin
        tmo_d   = '0;
        state_d = WAIT_LO;
      end
      WAIT_LO: begin
        tmo_d = tmo_inc;
        if (tmo_hit) begin
          err_d      = gnt_onehot(gnt);
          last_gnt_d = gnt;
          state_d    = IDLE;
        end else if (!spi_done) begin
          state_d = WAIT_HI;
        end
      end
      WAIT_HI: begin
        tmo_d = tmo_inc;
        if (spi_done) begin
          rd_data_d  = spi_rd_data;
          last_gnt_d = gnt;
          ack_d      = gnt_onehot(gnt);
          state_d    = RESP;
        end else if (tmo_hit) begin
          err_d      = gnt_onehot(gnt);
          last_gnt_d = gnt;
          state_d    = IDLE;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Only the granted device sees the master's select, and only while busy.
  always_comb begin
    ss_n = '1;
    if (state != IDLE) ss_n[gnt] = spi_SS_n;
  end

endmodule
